// File: rtl/dense_mac_seq_pkg.sv
// Shared constants and state encoding for the time-multiplexed dense layer.
package dense_mac_seq_pkg;

  localparam int FRAC_DEFAULT = 16;

  localparam logic ACT_ID   = 1'b0;
  localparam logic ACT_RELU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter width for an index range of n entries; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Activation select: identity, or ReLU (negative values clamp to zero).
module act_unit
  import dense_mac_seq_pkg::*;
#(
  parameter int BITSIZE = 24
) (
  input  logic               mode,
  input  logic [BITSIZE-1:0] d,
  output logic [BITSIZE-1:0] q
);

  assign q = (mode == ACT_ID || !d[BITSIZE-1]) ? d : '0;

endmodule

// File: rtl/fixed_point_add.sv
// Fixed-point add with plain wrap-around, no saturation.
module fixed_point_add #(
  parameter int BITSIZE = 24
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] s
);

  assign s = a + b;

endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiply: full-width product, floor shift by FRAC,
// low BITSIZE bits kept (wraps on overflow).
module fixed_point_multiply #(
  parameter int BITSIZE = 24,
  parameter int FRAC    = 16
) (
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] b,
  output logic [BITSIZE-1:0] p
);

  logic signed [2*BITSIZE-1:0] full;

  assign full = $signed({{BITSIZE{a[BITSIZE-1]}}, a}) * $signed({{BITSIZE{b[BITSIZE-1]}}, b});
  assign p    = BITSIZE'(full >>> FRAC);

endmodule

// File: rtl/dense_mac_seq.sv
// Fully-connected layer, one shared multiplier and adder, start/done handshake.
//   state   | meaning
//   IDLE    | waiting for start; captures x, w, b, act_mode on accept
//   MAC     | acc += x[i]*w[o][i], one input per cycle
//   WB      | y[o] <= act(acc); next row or finish
//   DONE    | done pulse cycle; start ignored here
module dense_mac_seq
  import dense_mac_seq_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int FRAC    = FRAC_DEFAULT,
  parameter int N_IN    = 6,
  parameter int N_OUT   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          act_mode,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                          busy,
  output logic                          done,
  output logic [BITSIZE*N_OUT-1:0]      y
);

  localparam int IW = cnt_width(N_IN);
  localparam int OW = cnt_width(N_OUT);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

  typedef logic [BITSIZE-1:0] word_t;

  word_t x_in [N_IN];
  word_t w_in [N_OUT][N_IN];
  word_t b_in [N_OUT];

  word_t x_r [N_IN];
  word_t w_r [N_OUT][N_IN];
  word_t b_r [N_OUT];
  word_t y_r [N_OUT];

  state_t        state;
  logic [IW-1:0] i;
  logic [OW-1:0] o;
  word_t         acc;
  logic          act_r;
  word_t         prod;
  word_t         sum;
  word_t         act_q;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
    assign x_in[gi] = x[BITSIZE*gi +: BITSIZE];
  end

  for (genvar go = 0; go < N_OUT; go++) begin : g_row
    assign b_in[go] = b[BITSIZE*go +: BITSIZE];
    assign y[BITSIZE*go +: BITSIZE] = y_r[go];
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_w
      assign w_in[go][gi] = w[BITSIZE*(go*N_IN + gi) +: BITSIZE];
    end
  end

  fixed_point_multiply #(.BITSIZE(BITSIZE), .FRAC(FRAC)) u_mul (
    .a(x_r[i]),
    .b(w_r[o][i]),
    .p(prod)
  );

  fixed_point_add #(.BITSIZE(BITSIZE)) u_add (
    .a(acc),
    .b(prod),
    .s(sum)
  );

  act_unit #(.BITSIZE(BITSIZE)) u_act (
    .mode(act_r),
    .d(acc),
    .q(act_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      i     <= '0;
      o     <= '0;
      acc   <= '0;
      act_r <= ACT_ID;
      for (int k = 0; k < N_IN; k++) x_r[k] <= '0;
      for (int r = 0; r < N_OUT; r++) begin
        b_r[r] <= '0;
        y_r[r] <= '0;
        for (int k = 0; k < N_IN; k++) w_r[r][k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_IN; k++) x_r[k] <= x_in[k];
            for (int r = 0; r < N_OUT; r++) begin
              b_r[r] <= b_in[r];
              for (int k = 0; k < N_IN; k++) w_r[r][k] <= w_in[r][k];
            end
            act_r <= act_mode;
            acc   <= b_in[0];
            i     <= '0;
            o     <= '0;
            busy  <= 1'b1;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= sum;
          if (i == I_LAST) begin
            i     <= '0;
            state <= ST_WB;
          end else begin
            i <= i + IW'(1);
          end
        end
        ST_WB: begin
          y_r[o] <= act_q;
          if (o != O_LAST) begin
            o     <= o + OW'(1);
            acc   <= b_r[o + OW'(1)];
            state <= ST_MAC;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_mac_seq.sv
// Scoreboard bench: stimulus pushes expected results, monitors check on done.
module tb_dense_mac_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic         start1 = 1'b0;
  logic         m1 = 1'b0;
  logic [143:0] x1 = '0;
  logic [143:0] w1 = '0;
  logic [23:0]  b1 = '0;
  logic         busy1, done1;
  logic [23:0]  y1;

  logic         start2 = 1'b0;
  logic         m2 = 1'b0;
  logic [143:0] x2 = '0;
  logic [287:0] w2 = '0;
  logic [47:0]  b2 = '0;
  logic         busy2, done2;
  logic [47:0]  y2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [47:0] y;
    int          c;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  dense_mac_seq u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .act_mode(m1),
    .x(x1), .w(w1), .b(b1), .busy(busy1), .done(done1), .y(y1)
  );

  dense_mac_seq #(.N_OUT(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .act_mode(m2),
    .x(x2), .w(w2), .b(b2), .busy(busy2), .done(done2), .y(y2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [143:0] fill6(input logic [23:0] v);
    return {6{v}};
  endfunction

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_done: got done at cycle %0d, required no done", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_y", {24'h0, y1}, e1.y);
        check("dut1_done_cycle", 48'(cyc), 48'(e1.c));
        check("dut1_busy_at_done", 48'(busy1), 48'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2_unexpected_done: got done at cycle %0d, required no done", cyc);
      end else begin
        e2 = q2.pop_front();
        check("dut2_y", y2, e2.y);
        check("dut2_done_cycle", 48'(cyc), 48'(e2.c));
        check("dut2_busy_at_done", 48'(busy2), 48'(0));
      end
    end
  end

  task automatic run1(input logic [143:0] xv, input logic [143:0] wv, input logic [23:0] bv,
                      input logic mv, input logic [23:0] ey, input string name);
    int a;
    @(negedge clk);
    x1 = xv; w1 = wv; b1 = bv; m1 = mv; start1 = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    q1.push_back(exp_t'{{24'h0, ey}, a + 7});
    check({name, "_busy_after_accept"}, 48'(busy1), 48'(1));
    @(negedge clk);
    start1 = 1'b0;
    x1 = ~xv; w1 = ~wv; b1 = ~bv; m1 = ~mv;
    repeat (9) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy1", 48'(busy1), 48'(0));
    check("rst_done1", 48'(done1), 48'(0));
    check("rst_y1", {24'h0, y1}, 48'h0);
    check("rst_busy2", 48'(busy2), 48'(0));
    check("rst_done2", 48'(done2), 48'(0));
    check("rst_y2", y2, 48'h0);
    @(negedge clk);
    reset = 1'b0;

    // Two output rows: y[0] at edge 7, y[1] and done at edge 14.
    @(negedge clk);
    x2 = fill6(24'h010000);
    w2 = {fill6(24'h010000), fill6(24'h008000)};
    b2 = {24'h000000, 24'h004000};
    m2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    q2.push_back(exp_t'{48'h060000_034000, a + 14});
    check("dut2_busy_after_accept", 48'(busy2), 48'(1));
    @(negedge clk);
    start2 = 1'b0;
    x2 = fill6(24'h020000);
    repeat (7) @(posedge clk); #1;
    check("dut2_y0_at_edge7", {24'h0, y2[23:0]}, 48'h034000);
    check("dut2_y1_hold_at_edge7", {24'h0, y2[47:24]}, 48'h0);
    check("dut2_busy_at_edge7", 48'(busy2), 48'(1));
    repeat (6) @(posedge clk); #1;
    check("dut2_y1_hold_at_edge13", {24'h0, y2[47:24]}, 48'h0);
    repeat (4) @(posedge clk);

    run1(fill6(24'h010000), fill6(24'h008000), 24'h004000, 1'b0, 24'h034000, "basic_id");
    run1(fill6(24'h010000), fill6(24'hFF8000), 24'h004000, 1'b0, 24'hFD4000, "neg_id");
    run1(fill6(24'h010000), fill6(24'hFF8000), 24'h004000, 1'b1, 24'h000000, "neg_relu");
    run1(fill6(24'h010000), fill6(24'h008000), 24'h004000, 1'b1, 24'h034000, "pos_relu");
    run1(fill6(24'hFFFFFF), fill6(24'h008000), 24'h000000, 1'b0, 24'hFFFFFA, "floor_shift");
    run1(fill6(24'h7F0000), fill6(24'h020000), 24'h000000, 1'b0, 24'hF40000, "overflow_wrap");
    run1({24'h060000, 24'h050000, 24'h040000, 24'h030000, 24'h020000, 24'h010000},
         {24'h010000, 24'h020000, 24'h030000, 24'h040000, 24'h050000, 24'h060000},
         24'h000000, 1'b0, 24'h380000, "index_pairing");

    // Re-pulsed start mid-run and in WB/DONE must be ignored; x changes after accept.
    @(negedge clk);
    x1 = fill6(24'h010000); w1 = fill6(24'h008000); b1 = 24'h004000; m1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    q1.push_back(exp_t'{{24'h0, 24'h034000}, a + 7});
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    x1 = fill6(24'h020000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(posedge clk);

    // Reset at edge 4 of a run aborts it.
    @(negedge clk);
    x1 = fill6(24'h010000); w1 = fill6(24'h008000); b1 = 24'h004000; m1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 48'(busy1), 48'(0));
    check("abort_done", 48'(done1), 48'(0));
    check("abort_y", {24'h0, y1}, 48'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    run1(fill6(24'h010000), fill6(24'h008000), 24'h004000, 1'b0, 24'h034000, "after_abort");

    // start held high: back-to-back runs every 9 cycles.
    @(negedge clk);
    x1 = fill6(24'h010000); w1 = fill6(24'h010000); b1 = 24'h000000; m1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    q1.push_back(exp_t'{{24'h0, 24'h060000}, a + 7});
    q1.push_back(exp_t'{{24'h0, 24'h060000}, a + 16});
    repeat (17) @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (12) @(posedge clk);

    @(negedge clk);
    check("dut1_queue_drained", 48'(q1.size()), 48'(0));
    check("dut2_queue_drained", 48'(q2.size()), 48'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
